// File: rtl/data_array_pkg.sv
// Shared state encoding and default geometry for the banked data array.
package data_array_pkg;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      BUSY
   } state_e;

   localparam int DEF_DATA_W = 128;
   localparam int DEF_ROW_W  = 6;
   localparam int DEF_BANKS  = 2;

endpackage

// File: rtl/data_array_sram.sv
// Single-port synchronous SRAM bank: per-byte active-low write enables, 1-cycle read,
// output register holds its value whenever the bank is not selected.
module data_array_sram #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 64
) (
   input  logic                       CK,
   input  logic                       CS,
   input  logic                       OE,
   input  logic [DATA_W/8-1:0]        WEB,
   input  logic [$clog2(DEPTH)-1:0]   A,
   input  logic [DATA_W-1:0]          DI,
   output logic [DATA_W-1:0]          DO
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] do_q;

   // A select with every WEB bit high is a read; any low bit makes it a (partial) write.
   always_ff @(posedge CK) begin
      if (CS) begin
         for (int unsigned i = 0; i < DATA_W/8; i++) begin
            if (!WEB[i]) begin
               mem[A][i*8 +: 8] <= DI[i*8 +: 8];
            end
         end
         if (&WEB) begin
            do_q <= mem[A];
         end
      end
   end

   assign DO = OE ? do_q : '0;

endmodule

// File: rtl/data_array_banked.sv
// Bank-interleaved data array with byte strobes and a single-entry read response.
// Define DATA_ARRAY_INIT_EN to zero every row of every bank after reset before use.
module data_array_banked
   import data_array_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ROW_W  = DEF_ROW_W,
   parameter int BANKS  = DEF_BANKS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_write,
   input  logic [ROW_W+$clog2(BANKS)-1:0] req_addr,
   input  logic [DATA_W/8-1:0]            req_wstrb,
   input  logic [DATA_W-1:0]              req_wdata,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [DATA_W-1:0]              rsp_rdata,
   output logic                           init_done
);

   localparam int NB     = DATA_W/8;
   localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam int ADDR_W = ROW_W + $clog2(BANKS);
   localparam int DEPTH  = 2**ROW_W;

   state_e            state_q, state_d;
   logic              init_done_q, init_done_d;
   logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
   logic [BANK_W-1:0] req_bank;
   logic [ROW_W-1:0]  req_row;
   logic              req_acc, rd_acc;
   logic              clearing;
   logic [ROW_W-1:0]  clr_a;
   logic [BANKS-1:0]  bank_cs;
   logic [NB-1:0]     bank_web [BANKS];
   logic [ROW_W-1:0]  sram_a;
   logic [DATA_W-1:0] sram_di;
   logic [DATA_W-1:0] bank_do [BANKS];

`ifdef DATA_ARRAY_INIT_EN
   localparam state_e RST_STATE = INIT;
   logic [ROW_W-1:0] clr_row_q, clr_row_d;
   logic             clr_last;

   assign clearing = (state_q == INIT);
   assign clr_a    = clr_row_q;
   assign clr_last = clearing && (clr_row_q == ROW_W'(DEPTH-1));

   always_comb begin
      clr_row_d = '0;
      if (clearing) begin
         clr_row_d = clr_row_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clr_row_q <= '0;
      end else begin
         clr_row_q <= clr_row_d;
      end
   end
`else
   localparam state_e RST_STATE = IDLE;
   assign clearing = 1'b0;
   assign clr_a    = '0;
`endif

   if (BANKS > 1) begin : g_bank_sel
      assign req_bank = req_addr[BANK_W-1:0];
   end else begin : g_single_bank
      assign req_bank = '0;
   end

   assign req_row   = req_addr[ADDR_W-1 -: ROW_W];
   assign rsp_valid = (state_q == BUSY);
   assign init_done = init_done_q;
   assign req_ready = init_done_q && (!rsp_valid || rsp_ready);
   assign req_acc   = req_valid && req_ready;
   assign rd_acc    = req_acc && !req_write;

   // While clearing, every bank writes the same row with zeros in parallel.
   always_comb begin
      bank_cs = '0;
      sram_a  = clearing ? clr_a : req_row;
      sram_di = clearing ? '0 : req_wdata;
      for (int unsigned b = 0; b < BANKS; b++) begin
         bank_web[b] = '1;
         if (clearing) begin
            bank_cs[b]  = 1'b1;
            bank_web[b] = '0;
         end else if (req_acc && (req_bank == BANK_W'(b))) begin
            bank_cs[b] = 1'b1;
            if (req_write) begin
               bank_web[b] = ~req_wstrb;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_bank_d = rd_acc ? req_bank : rd_bank_q;
      case (state_q)
`ifdef DATA_ARRAY_INIT_EN
         INIT:    if (clr_last) state_d = IDLE;
`endif
         IDLE:    if (rd_acc) state_d = BUSY;
         BUSY:    if (rsp_ready && !rd_acc) state_d = IDLE;
         default: state_d = RST_STATE;
      endcase
      init_done_d = init_done_q || (state_d != INIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RST_STATE;
         init_done_q <= 1'b0;
         rd_bank_q   <= '0;
      end else begin
         state_q     <= state_d;
         init_done_q <= init_done_d;
         rd_bank_q   <= rd_bank_d;
      end
   end

   // Response data comes straight from the bank output register, which holds while unselected.
   always_comb begin
      rsp_rdata = '0;
      for (int unsigned b = 0; b < BANKS; b++) begin
         if (rsp_valid && (rd_bank_q == BANK_W'(b))) begin
            rsp_rdata = bank_do[b];
         end
      end
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      data_array_sram #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_sram (
         .CK  (clk),
         .CS  (bank_cs[b]),
         .OE  (1'b1),
         .WEB (bank_web[b]),
         .A   (sram_a),
         .DI  (sram_di),
         .DO  (bank_do[b])
      );
   end

endmodule

// File: tb/tb_data_array_banked.sv
// Randomized bench for data_array_banked against a word-array reference model.
module tb_data_array_banked;

   localparam int DATA_W = 128;
   localparam int ROW_W  = 6;
   localparam int BANKS  = 2;
   localparam int NB     = DATA_W/8;
   localparam int AW     = ROW_W + 1;
   localparam int WORDS  = 2**AW;
`ifdef DATA_ARRAY_INIT_EN
   localparam int INIT_CYC = 64;
`else
   localparam int INIT_CYC = 1;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [AW-1:0]     req_addr = '0;
   logic [NB-1:0]     req_wstrb = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [DATA_W-1:0] rsp_rdata;
   logic              init_done;

   data_array_banked #(
      .DATA_W (DATA_W),
      .ROW_W  (ROW_W),
      .BANKS  (BANKS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wstrb (req_wstrb),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [DATA_W-1:0] m_mem [WORDS];
   logic              m_rvalid = 1'b0;
   logic [DATA_W-1:0] m_rdata = '0;
   logic              m_init = 1'b0;

   task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One bus cycle: drive just after the edge, compare at the falling edge, then advance the model.
   task automatic do_cycle(input logic v, input logic w, input logic [AW-1:0] a,
                           input logic [NB-1:0] s, input logic [DATA_W-1:0] d, input logic rr);
      logic             exp_ready;
      logic             acc;
      logic [BANKS-1:0] exp_cs;
      @(posedge clk);
      #1;
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wstrb = s;
      req_wdata = d;
      rsp_ready = rr;
      @(negedge clk);
      exp_ready = m_init && (!m_rvalid || rr);
      acc       = v && exp_ready;
      exp_cs    = '0;
      if (acc) exp_cs[a % BANKS] = 1'b1;
      check("req_ready", DATA_W'(req_ready), DATA_W'(exp_ready));
      check("rsp_valid", DATA_W'(rsp_valid), DATA_W'(m_rvalid));
      if (m_rvalid) check("rsp_rdata", rsp_rdata, m_rdata);
      check("bank_cs", DATA_W'(dut.bank_cs), DATA_W'(exp_cs));
      if (m_rvalid && rr) m_rvalid = 1'b0;
      if (acc) begin
         if (w) begin
            for (int i = 0; i < NB; i++) begin
               if (s[i]) m_mem[a][i*8 +: 8] = d[i*8 +: 8];
            end
         end else begin
            m_rvalid = 1'b1;
            m_rdata  = m_mem[a];
         end
      end
   endtask

   task automatic idle_cycle();
      do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
   endtask

   task automatic apply_reset(input int unsigned hold);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      rst      = 1'b0;
      m_rvalid = 1'b0;
      m_init   = 1'b0;
      check("rst_rsp_valid", DATA_W'(rsp_valid), '0);
      check("rst_rsp_rdata", rsp_rdata, '0);
      check("rst_init_done", DATA_W'(init_done), '0);
   endtask

   // Counts edges from reset release until init_done rises, offering a read the whole time.
   task automatic wait_init(input string tag);
      int unsigned n = 0;
      bit          seen = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = AW'(5);
      for (int unsigned i = 1; i <= INIT_CYC + 16 && !seen; i++) begin
         @(posedge clk);
         @(negedge clk);
         n = i;
         if (init_done) seen = 1'b1;
         else check("ready_in_init", DATA_W'(req_ready), '0);
      end
      req_valid = 1'b0;
      check(tag, DATA_W'(n), DATA_W'(INIT_CYC));
      check("no_rsp_in_init", DATA_W'(rsp_valid), '0);
      m_init = 1'b1;
`ifdef DATA_ARRAY_INIT_EN
      for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
`endif
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
      apply_reset(3);
`ifdef DATA_ARRAY_INIT_EN
      repeat (29) @(posedge clk);
      #1;
      check("init_mid", DATA_W'(init_done), '0);
      apply_reset(1);
`endif
      wait_init("init_latency");
`ifndef DATA_ARRAY_INIT_EN
      for (int a = 0; a < WORDS; a++) do_cycle(1'b1, 1'b1, AW'(a), '1, rand_word(), 1'b1);
`endif

      do_cycle(1'b1, 1'b0, AW'(5), '0, '0, 1'b1);
      idle_cycle();

      do_cycle(1'b1, 1'b1, AW'(3), NB'(1), {NB{8'hAA}}, 1'b1);
      do_cycle(1'b1, 1'b0, AW'(3), '0, '0, 1'b1);
      idle_cycle();

      do_cycle(1'b1, 1'b1, AW'(2), '1, rand_word(), 1'b1);
      do_cycle(1'b1, 1'b1, AW'(4), '1, rand_word(), 1'b1);
      do_cycle(1'b1, 1'b0, AW'(2), '0, '0, 1'b1);
      repeat (3) do_cycle(1'b1, 1'b0, AW'(4), '0, '0, 1'b0);
      do_cycle(1'b1, 1'b0, AW'(4), '0, '0, 1'b1);
      idle_cycle();
      idle_cycle();

      do_cycle(1'b1, 1'b1, AW'(7'h7F), '1, DATA_W'(16'h1234), 1'b1);
      do_cycle(1'b1, 1'b0, AW'(7'h7F), '0, '0, 1'b1);
      idle_cycle();

      do_cycle(1'b1, 1'b1, AW'(9), '0, rand_word(), 1'b1);
      do_cycle(1'b1, 1'b0, AW'(9), '0, '0, 1'b1);
      idle_cycle();

      for (int k = 0; k < 600; k++) begin
         logic [NB-1:0] s;
         s = ($urandom_range(0, 7) == 0) ? '0 : NB'($urandom);
         do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom),
                  s, rand_word(), $urandom_range(0, 3) != 0);
      end
      idle_cycle();
      idle_cycle();

      do_cycle(1'b1, 1'b0, AW'(6), '0, '0, 1'b0);
      apply_reset(1);
      wait_init("init_after_busy_rst");
      idle_cycle();
      for (int k = 0; k < 12; k++) begin
         do_cycle(1'b1, 1'b0, AW'($urandom), '0, '0, 1'b1);
      end
      idle_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_array_banked.md
DATA_ARRAY_BANKED -- requirements
Module: data_array_banked

Interface
REQ-001 SHALL have parameter DATA_W, default 128: word width in bits, multiple of 8.
REQ-002 SHALL have parameter ROW_W, default 6: row address bits per bank (DEPTH = 2**ROW_W rows).
REQ-003 SHALL have parameter BANKS, default 2: bank count, power of two, >= 1 (BANK_W = max(1, log2(BANKS))).
REQ-004 SHALL have the following ports, in this order:
- clk  in  1  clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ROW_W+log2(BANKS)  word address.
- req_wstrb  in  DATA_W/8  byte write strobes.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data present.
- rsp_ready  in  1  read data consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data.
- init_done  out  1  array usable.

Function
REQ-005 SHALL interleave banks: bank = req_addr[log2(BANKS)-1:0], row = the remaining upper bits; with BANKS=1, row = req_addr.
REQ-006 SHALL enable (CS) only the selected bank on an accepted request; unselected banks SHALL see CS=0 and all WEB bits high.
REQ-007 SHALL drive req_ready = init_done && (!rsp_valid || rsp_ready).
REQ-008 SHALL perform an accepted write in its acceptance cycle, writing byte i only when req_wstrb[i]=1.
- No response is produced.
- wstrb = 0 writes nothing.
REQ-009 SHALL assert rsp_valid with rsp_rdata exactly 1 cycle after an accepted read.
REQ-010 SHALL hold rsp_valid and rsp_rdata stable while rsp_valid && !rsp_ready.
REQ-011 SHALL deassert rsp_valid the cycle after the handshake, unless a new read was accepted in that same cycle; back-to-back reads SHALL sustain 1 per cycle when rsp_ready=1.
REQ-012 SHALL return the newly written data for a read accepted the cycle after a write to the same address.
REQ-013 SHALL implement FSM states INIT, IDLE, BUSY:
- INIT -> IDLE after the last clear write.
- IDLE -> BUSY on an accepted read.
- BUSY -> IDLE on the rsp handshake with no new read accepted.
- BUSY -> BUSY on the rsp handshake with a new read accepted, or while stalled.
REQ-014 SHALL ignore req_valid in INIT; req_ready SHALL be 0 throughout INIT.

Reset
REQ-015 SHALL, on rst=1, force: state = INIT (macro on) or IDLE (macro off); rsp_valid=0; rsp_rdata=0; init_done=0; clear row counter=0.
REQ-016 SHALL discard a pending response when rst asserts during BUSY; no rsp_valid after reset release.
REQ-017 SHALL restart clearing from row 0 when rst asserts mid-INIT.
REQ-018 SHALL leave array contents unchanged on rst when DATA_ARRAY_INIT_EN is not defined.

Configuration
REQ-019 SHALL use macro DATA_ARRAY_INIT_EN to select the reset-time clear:
- Defined: after reset, INIT writes all-zero, all bytes, to row k of every bank simultaneously for k = 0..DEPTH-1 (DEPTH cycles). init_done=1 the cycle after row DEPTH-1 is written.
- Undefined: no INIT state logic; init_done=1 from the first cycle after rst deasserts; array contents are undefined until written.

Structure
REQ-020 SHALL place in package data_array_pkg: the state enum (INIT/IDLE/BUSY) and the default constants DATA_W=128, ROW_W=6, BANKS=2.
REQ-021 SHALL instantiate BANKS copies of sub-module data_array_sram, each with:
- parameterised DEPTH x DATA_W storage;
- CK, CS, OE and per-byte active-low WEB;
- 1-cycle read latency;
- DO held while CS=0.

Verification (defaults, INIT_EN defined unless stated)
REQ-022 SHALL check the clear sequence: release reset -> init_done rises exactly 64 cycles later; read addr 0x05 -> rsp_rdata = 0.
REQ-023 SHALL check a masked write: write addr 0x03, wdata = all 0xAA, wstrb = 0x0001; then read 0x03 -> rdata = 0x...00AA (byte 0 = 0xAA, others 0); bank 1 CS only.
REQ-024 SHALL check stall and back-to-back reads: read 0x02 then 0x04 with rsp_ready=0 for 3 cycles -> req_ready=0; rsp_rdata(0x02) stable; second read accepted only on the handshake cycle.
REQ-025 SHALL check write-then-read: write 0x7F = 0x1234 (wstrb all ones) followed immediately by read 0x7F -> rsp_valid next cycle, rdata = 0x1234.
REQ-026 SHALL check reset mid-operation: rst during INIT at row 30 -> clear restarts at row 0; rst during BUSY -> rsp_valid=0 next cycle.
REQ-027 SHALL check the macro-off build: INIT_EN undefined -> init_done=1 one cycle after reset; first request accepted immediately.
